ram_note_fetcher: RTL and testbench

- Upstream sequencer for the cellular-RAM interface stage. Walks a song's note chart stored in external RAM, one 16-bit word per address.
- Drives address and read select into the RAM stage and honours the async RAM access time with a wait-state counter.
- Buffers fetched words in a small first-word-fall-through (FWFT) FIFO.
- Hands words to the game/note-scheduler logic over a valid/ready handshake.

---
 rtl/drums_ram_pkg.sv | 17 +
 rtl/note_fifo.sv | 72 +++++++
 rtl/ram_note_fetcher.sv | 145 ++++++++++++++
 tb/tb_ram_note_fetcher.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drums_ram_pkg.sv
// Shared constants, end-of-chart marker and fetch FSM state type for the RAM note path.
package drums_ram_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    localparam logic [15:0] END_MARKER = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAITQ,
        SETUP,
        NEXT,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/note_fifo.sv
// Small first-word-fall-through FIFO buffering fetched note words for the scheduler.
module note_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              has_free
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_CNT);
        has_free = (count_q < DEPTH_CNT);
        do_push  = push && !full;
        do_pop   = pop && !empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        // Gate the head with empty so stale storage never shows after reset.
        dout = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_note_fetcher.sv
// Walks a note chart in async RAM, honouring access time, and queues words for the scheduler.
// Optional END_MARKER_EN: a fetched 16'hFFFF ends the chart early and is not queued.
module ram_note_fetcher
    import drums_ram_pkg::*;
#(
    parameter int ADDR_W      = drums_ram_pkg::ADDR_W,
    parameter int DATA_W      = drums_ram_pkg::DATA_W,
    parameter int WAIT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length_words,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read_sel,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] note_data,
    output logic              note_valid,
    input  logic              note_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;

    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_free;
    logic              is_marker;

`ifdef END_MARKER_EN
    assign is_marker = (rdata_q == DATA_W'(END_MARKER));
`else
    assign is_marker = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        ram_addr_d  = ram_addr_q;
        wait_cnt_d  = wait_cnt_q;
        rdata_d     = rdata_q;
        fifo_push   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length_words;
                    state_d     = (length_words == '0) ? DONE : WAITQ;
                end
            end
            WAITQ: begin
                // Only launch an access when its word is guaranteed a slot.
                if (fifo_free) begin
                    ram_addr_d = addr_q;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (wait_cnt_q == '0) begin
                    rdata_d = ram_rdata;
                    state_d = NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            NEXT: begin
                if (is_marker) begin
                    state_d = DONE;
                end else begin
                    // The slot was reserved in WAITQ, so full never blocks this push.
                    fifo_push   = !fifo_full;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == ADDR_W'(1)) ? DONE : WAITQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_q == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            ram_addr_q  <= ram_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

    note_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_note_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (note_ready),
        .din     (rdata_q),
        .dout    (note_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .has_free(fifo_free)
    );

    assign ram_addr     = ram_addr_q;
    assign ram_read_sel = 1'b1;
    assign note_valid   = !fifo_empty;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_ram_note_fetcher.sv
// Self-checking bench for ram_note_fetcher with a timed async-RAM model and a note-list reference.
module tb_ram_note_fetcher;

    localparam int ADDR_W      = 23;
    localparam int DATA_W      = 16;
    localparam int WAIT_CYCLES = 4;
    localparam int FIFO_DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length_words;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_read_sel;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] note_data;
    logic              note_valid;
    logic              note_ready;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    ram_note_fetcher #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .length_words(length_words),
        .ram_addr    (ram_addr),
        .ram_read_sel(ram_read_sel),
        .ram_rdata   (ram_rdata),
        .note_data   (note_data),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // RAM contents: address low bits xor a key, with an optional planted marker word.
    logic [15:0]       key = 16'h0000;
    logic              marker_on = 1'b0;
    logic [ADDR_W-1:0] marker_addr = '0;

    function automatic logic [15:0] ram_word(input logic [ADDR_W-1:0] a);
        if (marker_on && a == marker_addr) return 16'hFFFF;
        return a[15:0] ^ key;
    endfunction

    // Data is only correct once the address has been held WAIT_CYCLES cycles.
    logic [ADDR_W-1:0] held_addr;
    int                held = 0;
    always @(negedge clock) begin
        if (ram_addr !== held_addr) begin
            held_addr = ram_addr;
            held = 1;
        end else begin
            held++;
        end
        ram_rdata = (held >= WAIT_CYCLES) ? ram_word(ram_addr) : ~ram_word(ram_addr);
    end

    int ready_mode = 0;
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       note_ready = 1'b1;
            1:       note_ready = 1'b0;
            default: note_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [15:0]       got[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [ADDR_W-1:0] last_addr;
    int                done_cnt = 0;
    int                sel_bad = 0;
    int                valid_seen = 0;
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (note_valid && note_ready) got.push_back(note_data);
            if (done) done_cnt++;
            if (ram_read_sel !== 1'b1) sel_bad++;
            if (note_valid) valid_seen++;
            if (ram_addr !== last_addr) begin
                addr_log.push_back(ram_addr);
                last_addr = ram_addr;
            end
        end
    end

    function automatic void model_notes(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                                        output logic [15:0] q[$]);
        logic [ADDR_W-1:0] a;
        logic [15:0]       w;
        a = base;
        q = {};
        for (int i = 0; i < int'(len); i++) begin
            w = ram_word(a);
`ifdef END_MARKER_EN
            if (w == 16'hFFFF) break;
`endif
            q.push_back(w);
            a = a + 1'b1;
        end
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        cycle();
        base_addr    = base;
        length_words = len;
        start        = 1'b1;
        cycle();
        start        = 1'b0;
    endtask

    task automatic finish_fetch(input string name, input int g0, input int d0,
                                input logic [15:0] exp[$], input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: waited %0d cycles, done never pulsed", name, n);
        end
        n = 0;
        while (got.size() - g0 < exp.size() && n < 400) begin
            cycle();
            n++;
        end
        repeat (10) cycle();
        checks++;
        if (got.size() - g0 !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d notes, expected %0d", name, got.size() - g0, exp.size());
        end
        for (int i = 0; i < exp.size() && g0 + i < got.size(); i++) begin
            checks++;
            if (got[g0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL %s_note%0d: got %h expected %h", name, i, got[g0 + i], exp[i]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - d0);
        end
        checks++;
        if (sel_bad !== 0) begin
            errors++;
            $display("FAIL %s_read_sel: %0d cycles with ram_read_sel != 1, expected 0", name, sel_bad);
        end
    endtask

    task automatic run_and_check(input string name, input logic [ADDR_W-1:0] base,
                                 input logic [ADDR_W-1:0] len);
        logic [15:0] exp[$];
        int g0, d0;
        model_notes(base, len, exp);
        g0 = got.size();
        d0 = done_cnt;
        pulse_start(base, len);
        finish_fetch(name, g0, d0, exp, int'(len) * 40 + 60);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ram_addr !== '0 || ram_read_sel !== 1'b1 || note_valid !== 1'b0 ||
            note_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: addr=%h sel=%b valid=%b data=%h busy=%b done=%b expected 0,1,0,0,0,0",
                     name, ram_addr, ram_read_sel, note_valid, note_data, busy, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length_words = '0;
        repeat (3) cycle();
        check_reset_outputs("reset_values");
        reset_n = 1'b1;
        repeat (2) cycle();
        check_reset_outputs("after_reset_idle");
    endtask

    task automatic test_basic();
        logic [15:0] exp[$];
        int g0, d0, n;
        key = 16'h0000;
        marker_on = 1'b0;
        ready_mode = 0;
        model_notes(23'h000100, 23'd3, exp);
        g0 = got.size();
        d0 = done_cnt;
        pulse_start(23'h000100, 23'd3);
        n = 0;
        while (!note_valid && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL basic_latency: note_valid after %0d edges, expected 6", n);
        end
        finish_fetch("basic", g0, d0, exp, 100);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp[$];
        int g0, d0;
        key = 16'h1234;
        ready_mode = 1;
        repeat (2) cycle();
        model_notes(23'h000200, 23'd8, exp);
        g0 = got.size();
        d0 = done_cnt;
        pulse_start(23'h000200, 23'd8);
        repeat (60) cycle();
        checks++;
        if (busy !== 1'b1 || ram_addr !== 23'h000203 || done_cnt !== d0) begin
            errors++;
            $display("FAIL bp_hold: busy=%b addr=%h dones=%0d expected 1, 000203, 0",
                     busy, ram_addr, done_cnt - d0);
        end
        checks++;
        if (note_valid !== 1'b1 || note_data !== exp[0] || got.size() !== g0) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h popped=%0d expected 1, %h, 0",
                     note_valid, note_data, got.size() - g0, exp[0]);
        end
        ready_mode = 0;
        finish_fetch("backpressure", g0, d0, exp, 200);
    endtask

    task automatic test_zero_length();
        logic [ADDR_W-1:0] a0;
        int v0, d0;
        ready_mode = 0;
        repeat (3) cycle();
        a0 = ram_addr;
        v0 = valid_seen;
        d0 = done_cnt;
        pulse_start(23'h001000, 23'd0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_early: done=%b one edge after start, expected 0", done);
        end
        cycle();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b two cycles after start, expected 1", done);
        end
        repeat (5) cycle();
        checks++;
        if (ram_addr !== a0 || valid_seen !== v0 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_side_effects: addr=%h valid_cycles=%0d dones=%0d busy=%b expected %h, 0, 1, 0",
                     ram_addr, valid_seen - v0, done_cnt - d0, busy, a0);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_addr[4];
        int a0;
        exp_addr[0] = 23'h7FFFFE;
        exp_addr[1] = 23'h7FFFFF;
        exp_addr[2] = 23'h000000;
        exp_addr[3] = 23'h000001;
        key = 16'h0000;
        a0 = addr_log.size();
        run_and_check("wrap", 23'h7FFFFE, 23'd4);
        checks++;
        if (addr_log.size() - a0 !== 4) begin
            errors++;
            $display("FAIL wrap_addr_count: got %0d addresses, expected 4", addr_log.size() - a0);
        end
        for (int i = 0; i < 4 && a0 + i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[a0 + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got %h expected %h", i, addr_log[a0 + i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n, d0;
        key = 16'h5A5A;
        ready_mode = 0;
        d0 = done_cnt;
        pulse_start(23'h000300, 23'd5);
        n = 0;
        while (ram_addr !== 23'h000301 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (ram_addr !== 23'h000301) begin
            errors++;
            $display("FAIL rmid_reach_word2: addr=%h expected 000301", ram_addr);
        end
        repeat (2) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rmid_async_reset");
        cycle();
        reset_n = 1'b1;
        repeat (10) cycle();
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: dones=%0d busy=%b expected 0, 0", done_cnt - d0, busy);
        end
        run_and_check("rmid_restart", 23'h000450, 23'd3);
    endtask

    task automatic test_end_marker();
        logic [15:0] exp[$];
        int g0, exp_n;
        key = 16'h0F0F;
        marker_on = 1'b1;
        marker_addr = 23'h000502;
        ready_mode = 0;
`ifdef END_MARKER_EN
        exp_n = 2;
`else
        exp_n = 10;
`endif
        model_notes(23'h000500, 23'd10, exp);
        g0 = got.size();
        run_and_check("marker", 23'h000500, 23'd10);
        checks++;
        if (got.size() - g0 !== exp_n) begin
            errors++;
            $display("FAIL marker_delivered: got %0d notes, expected %0d", got.size() - g0, exp_n);
        end
        marker_on = 1'b0;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base, len;
        for (int it = 0; it < 6; it++) begin
            key         = 16'($urandom);
            base        = ADDR_W'($urandom);
            len         = ADDR_W'($urandom_range(1, 10));
            marker_on   = 1'($urandom_range(0, 1));
            marker_addr = base + ADDR_W'($urandom_range(0, 9));
            ready_mode  = 2;
            run_and_check($sformatf("random%0d", it), base, len);
        end
        marker_on = 1'b0;
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_wrap();
        test_reset_mid_fetch();
        test_end_marker();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
